// File: rtl/regfile_2r1w_sync.sv
// Purpose: parametrised 2-read/1-write flip-flop register file with byte-masked writes and a sequenced zero-fill engine.
// Latency: reads are registered, data and valid pulse one edge after the request; a write is visible to a same-edge read (write-first bypass).
// Backpressure: none on the ports; while Busy is high all read, write and clear requests are ignored.
//
// Ports:
//   clk, reset             - clock and synchronous active-high reset (reset starts a full clear)
//   ClearReq / Busy        - request a zero-fill when idle / high while the clear engine runs
//   WriteEn, WriteReg,
//   WriteData, WriteByteEn - write strobe, address, data and per-byte enable
//   ReadEnX, ReadRegX      - read request and address for port X (A or B)
//   ReadDataX, ReadValidX  - registered read data and its one-cycle valid pulse
module regfile_2r1w_sync #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ClearReq,
    output logic                  Busy,
    input  logic                  WriteEn,
    input  logic [ADDR_W-1:0]     WriteReg,
    input  logic [DATA_W-1:0]     WriteData,
    input  logic [DATA_W/8-1:0]   WriteByteEn,
    input  logic                  ReadEnA,
    input  logic [ADDR_W-1:0]     ReadRegA,
    output logic [DATA_W-1:0]     ReadDataA,
    output logic                  ReadValidA,
    input  logic                  ReadEnB,
    input  logic [ADDR_W-1:0]     ReadRegB,
    output logic [DATA_W-1:0]     ReadDataB,
    output logic                  ReadValidB
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, stateNext;
    logic [ADDR_W-1:0]   ClrIdx, clrIdxNext;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   oldWord, mergedWord, memA, memB, rdWordA, rdWordB;
    logic                wrHit;

    assign Busy = (state == CLEAR);

    // An address is usable when it maps to a real entry and is not the
    // hardwired-zero entry. Unusable addresses drop writes and read as 0.
    function automatic logic addrOk(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W + 1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR;
            ClrIdx <= '0;
        end else begin
            state  <= stateNext;
            ClrIdx <= clrIdxNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrIdxNext = ClrIdx;
        case (state)
            IDLE: begin
                if (ClearReq) begin
                    stateNext  = CLEAR;
                    clrIdxNext = '0;
                end
            end
            CLEAR: begin
                if (ClrIdx == LAST_IDX) begin
                    stateNext  = IDLE;
                    clrIdxNext = '0;
                end else begin
                    clrIdxNext = ClrIdx + ADDR_W'(1);
                end
            end
            default: begin
                stateNext  = CLEAR;
                clrIdxNext = '0;
            end
        endcase
    end

    // ---------------- array read muxes and write merge ----------------
    always_comb begin
        oldWord = '0;
        memA    = '0;
        memB    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (WriteReg == ADDR_W'(i)) oldWord = mem[i];
            if (ReadRegA == ADDR_W'(i)) memA    = mem[i];
            if (ReadRegB == ADDR_W'(i)) memB    = mem[i];
        end
        mergedWord = oldWord;
        for (int b = 0; b < NB; b++) begin
            if (WriteByteEn[b]) mergedWord[8*b +: 8] = WriteData[8*b +: 8];
        end
    end

    // A ClearReq edge drops the write that accompanies it.
    assign wrHit = !Busy && !ClearReq && WriteEn && addrOk(WriteReg);

    // Write-first: a read of the word being written sees the merged result.
    always_comb begin
        rdWordA = '0;
        rdWordB = '0;
        if (addrOk(ReadRegA)) rdWordA = (wrHit && (ReadRegA == WriteReg)) ? mergedWord : memA;
        if (addrOk(ReadRegB)) rdWordB = (wrHit && (ReadRegB == WriteReg)) ? mergedWord : memB;
    end

    // Storage has no reset of its own; reset starts the clear engine which
    // zero-fills it one entry per edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (Busy && (ClrIdx == ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wrHit && (WriteReg == ADDR_W'(i))) begin
                    mem[i] <= mergedWord;
                end
            end
        end
    end

    // ---------------- registered read ports ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadDataA  <= '0;
            ReadValidA <= 1'b0;
            ReadDataB  <= '0;
            ReadValidB <= 1'b0;
        end else begin
            ReadValidA <= !Busy && ReadEnA;
            ReadValidB <= !Busy && ReadEnB;
            if (!Busy && ReadEnA) ReadDataA <= rdWordA;
            if (!Busy && ReadEnB) ReadDataB <= rdWordB;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_sync.sv
// Purpose: directed self-checking bench for regfile_2r1w_sync (default 8x16 and a DEPTH=6 ZERO_REG=1 build).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: every wait on Busy is bounded; a global time limit ends a stuck run.
module tb_regfile_2r1w_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        ClearReq, Busy, WriteEn, ReadEnA, ReadEnB, ReadValidA, ReadValidB;
    logic [2:0]  WriteReg, ReadRegA, ReadRegB;
    logic [15:0] WriteData, ReadDataA, ReadDataB;
    logic [1:0]  WriteByteEn;

    logic        zClearReq, zBusy, zWriteEn, zReadEnA, zReadEnB, zReadValidA, zReadValidB;
    logic [2:0]  zWriteReg, zReadRegA, zReadRegB;
    logic [15:0] zWriteData, zReadDataA, zReadDataB;
    logic [1:0]  zWriteByteEn;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    regfile_2r1w_sync u_dut (
        .clk(clk), .reset(reset), .ClearReq(ClearReq), .Busy(Busy),
        .WriteEn(WriteEn), .WriteReg(WriteReg), .WriteData(WriteData), .WriteByteEn(WriteByteEn),
        .ReadEnA(ReadEnA), .ReadRegA(ReadRegA), .ReadDataA(ReadDataA), .ReadValidA(ReadValidA),
        .ReadEnB(ReadEnB), .ReadRegB(ReadRegB), .ReadDataB(ReadDataB), .ReadValidB(ReadValidB)
    );

    regfile_2r1w_sync #(.DATA_W(16), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1)) u_zero (
        .clk(clk), .reset(reset), .ClearReq(zClearReq), .Busy(zBusy),
        .WriteEn(zWriteEn), .WriteReg(zWriteReg), .WriteData(zWriteData), .WriteByteEn(zWriteByteEn),
        .ReadEnA(zReadEnA), .ReadRegA(zReadRegA), .ReadDataA(zReadDataA), .ReadValidA(zReadValidA),
        .ReadEnB(zReadEnB), .ReadRegB(zReadRegB), .ReadDataB(zReadDataB), .ReadValidB(zReadValidB)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        WriteEn = 1'b1; WriteReg = a; WriteData = d; WriteByteEn = be;
        tick();
        WriteEn = 1'b0; WriteByteEn = 2'b00;
    endtask

    task automatic doRead(input logic [2:0] a, input logic [2:0] b);
        ReadEnA = 1'b1; ReadRegA = a; ReadEnB = 1'b1; ReadRegB = b;
        tick();
        ReadEnA = 1'b0; ReadEnB = 1'b0;
    endtask

    // Counts edges until Busy falls, bounded so a stuck engine still reaches the summary.
    task automatic waitIdle(input string tag, input int expEdges);
        int n = 0;
        while (Busy && n < 20) begin
            tick();
            n++;
        end
        checkVal(tag, n, expEdges);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ClearReq = 1'b0; WriteEn = 1'b0; WriteReg = '0; WriteData = '0; WriteByteEn = '0;
        ReadEnA = 1'b0; ReadRegA = '0; ReadEnB = 1'b0; ReadRegB = '0;
        zClearReq = 1'b0; zWriteEn = 1'b0; zWriteReg = '0; zWriteData = '0; zWriteByteEn = '0;
        zReadEnA = 1'b0; zReadRegA = '0; zReadEnB = 1'b0; zReadRegB = '0;

        // Reset for two edges, then clear timing.
        tick();
        tick();
        checkVal("rst_busy", Busy, 1);
        checkVal("rst_dataA", ReadDataA, 0);
        checkVal("rst_validA", ReadValidA, 0);
        checkVal("rst_validB", ReadValidB, 0);
        reset = 1'b0;
        ReadEnA = 1'b1; ReadRegA = 3'd1;
        tick();
        checkVal("busy_rd_validA", ReadValidA, 0);
        checkVal("busy_after_1", Busy, 1);
        ReadEnA = 1'b0;
        waitIdle("clear_edges_after_reset", 7);

        for (int i = 0; i < 8; i++) begin
            doRead(3'(i), 3'(i));
            checkVal($sformatf("post_clr_rd%0d", i), ReadDataA, 0);
        end

        // Basic write/read.
        doWrite(3'd3, 16'hBEEF, 2'b11);
        doWrite(3'd6, 16'h1234, 2'b11);
        doRead(3'd3, 3'd6);
        checkVal("basic_A", ReadDataA, 16'hBEEF);
        checkVal("basic_B", ReadDataB, 16'h1234);
        checkVal("basic_vA", ReadValidA, 1);
        checkVal("basic_vB", ReadValidB, 1);
        tick();
        checkVal("pulse_vA", ReadValidA, 0);
        checkVal("pulse_vB", ReadValidB, 0);
        checkVal("hold_A", ReadDataA, 16'hBEEF);

        // Byte mask: only the low byte changes.
        doWrite(3'd3, 16'h55AA, 2'b01);
        doRead(3'd3, 3'd3);
        checkVal("mask_A", ReadDataA, 16'hBEAA);
        doWrite(3'd3, 16'h0000, 2'b00);
        doRead(3'd3, 3'd3);
        checkVal("mask_none", ReadDataA, 16'hBEAA);

        // Bypass on both ports with a high-byte-only write.
        doWrite(3'd5, 16'h00FF, 2'b11);
        WriteEn = 1'b1; WriteReg = 3'd5; WriteData = 16'hA5A5; WriteByteEn = 2'b10;
        doRead(3'd5, 3'd5);
        WriteEn = 1'b0; WriteByteEn = 2'b00;
        checkVal("bypass_A", ReadDataA, 16'hA5FF);
        checkVal("bypass_B", ReadDataB, 16'hA5FF);
        doRead(3'd5, 3'd3);
        checkVal("bypass_stored", ReadDataA, 16'hA5FF);

        // ClearReq with a write to reg 2 on the same edge.
        for (int i = 0; i < 8; i++) doWrite(3'(i), 16'(16'h1111 * (i + 1)), 2'b11);
        doRead(3'd7, 3'd2);
        checkVal("fill_7", ReadDataA, 16'h8888);
        checkVal("fill_2", ReadDataB, 16'h3333);
        ClearReq = 1'b1;
        doWrite(3'd2, 16'h7777, 2'b11);
        ClearReq = 1'b0;
        checkVal("clrreq_busy", Busy, 1);
        waitIdle("clear_edges_req", 8);
        for (int i = 0; i < 8; i++) begin
            doRead(3'(i), 3'd2);
            checkVal($sformatf("clrreq_rd%0d", i), ReadDataA, 0);
        end

        // Reset when ClrIdx reaches 4 restarts the full clear.
        doWrite(3'd7, 16'h9999, 2'b11);
        doRead(3'd7, 3'd7);
        checkVal("pre_rst_A", ReadDataA, 16'h9999);
        ClearReq = 1'b1;
        tick();
        ClearReq = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkVal("mid_clear_busy", Busy, 1);
        reset = 1'b1;
        tick();
        checkVal("midrst_dataA", ReadDataA, 0);
        tick();
        reset = 1'b0;
        waitIdle("clear_edges_restart", 8);
        doRead(3'd7, 3'd6);
        checkVal("restart_rd7", ReadDataA, 0);

        // ZERO_REG=1, DEPTH=6 build.
        checkVal("zero_idle", zBusy, 0);
        zWriteEn = 1'b1; zWriteByteEn = 2'b11; zWriteData = 16'hFFFF; zWriteReg = 3'd0;
        tick();
        zWriteReg = 3'd7;
        tick();
        zWriteReg = 3'd4; zWriteData = 16'h1234;
        tick();
        zWriteEn = 1'b0;
        zReadEnA = 1'b1; zReadRegA = 3'd0; zReadEnB = 1'b1; zReadRegB = 3'd7;
        tick();
        checkVal("zero_rd0", zReadDataA, 0);
        checkVal("zero_rd7", zReadDataB, 0);
        checkVal("zero_v0", zReadValidA, 1);
        checkVal("zero_v7", zReadValidB, 1);
        zReadRegA = 3'd4; zReadRegB = 3'd0;
        zWriteEn = 1'b1; zWriteReg = 3'd0; zWriteData = 16'hFFFF;
        tick();
        zWriteEn = 1'b0; zReadEnA = 1'b0; zReadEnB = 1'b0;
        checkVal("zero_rd4", zReadDataA, 16'h1234);
        checkVal("zero_bypass0", zReadDataB, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sync.md
Name: regfile_2r1w_sync

Overview:
- Parametrised successor to the 8x16 two-read/one-write register file.
- Adds configurable width and depth, byte-masked writes, registered read ports with write-first bypass, an optional hardwired-zero entry, and a sequenced clear engine.
- Sits between the datapath decode stage and the ALU operand latches.
- All storage is flip-flops. No memory macro.

Parameters:
- DATA_W, 16, word width in bits. Must be a multiple of 8.
- DEPTH, 8, number of entries. Must be at least 2.
- ADDR_W, 3, address width. Must satisfy 2**ADDR_W >= DEPTH.
- ZERO_REG, 0. When 1, entry 0 always reads 0 and writes to it are dropped.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- ClearReq  in  1  request a full zero-fill of the array (honoured only when idle)
- Busy  out  1  high while the clear engine runs; reads and writes are ignored while high
- WriteEn  in  1  write strobe
- WriteReg  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- WriteByteEn  in  DATA_W/8  per-byte write enable; bit i covers bits [8i+7:8i]
- ReadEnA  in  1  read request, port A
- ReadRegA  in  ADDR_W  read address, port A
- ReadDataA  out  DATA_W  registered read data, port A
- ReadValidA  out  1  one-cycle pulse: ReadDataA was updated this cycle
- ReadEnB, ReadRegB, ReadDataB, ReadValidB: identical to port A, for port B

Behaviour:
- One clock domain (clk). Synchronous active-high reset. Nothing is asynchronous.
- FSM states: IDLE, CLEAR. Clear index ClrIdx is ADDR_W bits.
- reset high at an edge:
  - state becomes CLEAR, ClrIdx becomes 0, Busy becomes 1.
  - ReadDataA and ReadDataB become 0; ReadValidA and ReadValidB become 0.
  - While reset is held, the FSM stays at ClrIdx 0.
- CLEAR, each edge:
  - entry[ClrIdx] is set to 0 and ClrIdx increments.
  - The edge that writes entry DEPTH-1 moves the FSM to IDLE and drops Busy.
  - A clear therefore takes exactly DEPTH edges after reset deasserts.
- CLEAR ignores WriteEn, ReadEnA, ReadEnB and ClearReq. ReadValid stays 0 and ReadData holds its value.
- IDLE with ClearReq=1: moves to CLEAR with ClrIdx 0 on that edge. A write presented on the same edge is dropped.
- Write, in IDLE only:
  - On an edge with WriteEn=1, each byte i of entry[WriteReg] with WriteByteEn[i]=1 takes WriteData byte i.
  - Bytes with WriteByteEn[i]=0 keep their value.
  - WriteByteEn all zero is a no-op.
- Read, in IDLE only, latency 1:
  - On an edge with ReadEnX=1, ReadDataX is loaded and ReadValidX=1 for that cycle.
  - With ReadEnX=0, ReadDataX holds and ReadValidX=0.
- Bypass (write-first):
  - Applies when a read and a write on the same edge have ReadRegX==WriteReg and WriteEn=1.
  - ReadDataX gets the post-write merged word: new bytes where enabled, old bytes elsewhere.
  - Both ports may bypass on the same edge.
- ZERO_REG=1:
  - Reads of address 0 return 0, including under bypass.
  - Writes to address 0 are dropped.
- Address at or above DEPTH (non-power-of-two DEPTH):
  - Writes are dropped.
  - Reads return 0 with ReadValid=1.
- Reset asserted during CLEAR restarts the clear at ClrIdx 0.
- Array contents are undefined only before the first clear completes. No entry holds X once Busy has fallen.

Test Plan:
- Reset and clear timing: reset for 2 cycles, then released.
  - Busy stays 1 for exactly 8 edges after release, then 0.
  - Read A of all 8 entries returns 0x0000.
  - During Busy, a ReadEnA=1 pulse gives ReadValidA=0.
- Basic write/read:
  - Write 0xBEEF to reg 3 and 0x1234 to reg 6 (WriteByteEn=2'b11).
  - Next cycle, read A=3 and B=6: one edge later ReadDataA=0xBEEF, ReadDataB=0x1234, both valid pulses for one cycle.
- Byte mask: reg 3 holds 0xBEEF.
  - Write 0x55AA with WriteByteEn=2'b01.
  - Reading reg 3 returns 0xBEAA.
- Bypass: reg 5 holds 0x00FF.
  - On the same edge: write 0xA5A5 to reg 5 with mask 2'b10, and read A=5, B=5.
  - Both ports return 0xA5FF.
- ClearReq mid-traffic:
  - Fill regs 0-7 with nonzero data, then pulse ClearReq with a write to reg 2 (0x7777) on the same edge.
  - Busy holds 8 cycles, the write is dropped, and all reads afterwards return 0.
  - Reset asserted at ClrIdx=4 restarts the clear: Busy lasts another full 8 cycles after reset releases.
- ZERO_REG=1, DEPTH=6:
  - Write 0xFFFF to reg 0 and reg 7, then read both.
  - Both return 0x0000. The reg-7 read gives ReadValid=1.
